tx_mac_framer: RTL
==================

Name: tx_mac_framer

Overview:
Transmit-side MAC framer. It is the counterpart to the receive MAC path.
- Accepts a byte-wide payload stream with a valid/ready/last handshake, plus per-frame header fields.
- Emits a complete GMII frame: preamble, SFD, 14-byte header, payload, zero pad to minimum size, FCS.
- Enforces the inter-frame gap.
- Output feeds the SDR→DDR RGMII transmit converter.

Parameters:
IFG_BYTES, 12, idle byte-times after each frame (min 1)
MIN_PAYLOAD, 46, payload bytes below which zero padding is appended
MAX_PAYLOAD, 1500, payload bytes above which the frame is aborted

Ports:
clk  in  1  core clock, one GMII byte per cycle
rst  in  1  synchronous, active-high reset
s_data_i  in  8  payload byte
s_valid_i  in  1  payload byte valid
s_last_i  in  1  final payload byte of the frame
s_ready_o  out  1  payload byte accepted when s_valid_i && s_ready_o
dst_mac_i  in  48  destination MAC, sampled at frame start; byte [47:40] is sent first
src_mac_i  in  48  source MAC, sampled at frame start
ethertype_i  in  16  EtherType/length, sampled at frame start; byte [15:8] is sent first
gmii_txd_o  out  8  GMII transmit data (registered)
gmii_tx_en_o  out  1  GMII transmit enable (registered)
gmii_tx_er_o  out  1  GMII transmit error (registered)
busy_o  out  1  high from frame start until IFG completes
frame_done_o  out  1  one-cycle pulse on the last FCS byte
underrun_o  out  1  one-cycle pulse on underrun or oversize abort

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; CRC register 0xFFFFFFFF.
- States: IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, DRAIN, IFG.
- IDLE: s_ready_o=0. When s_valid_i=1, latch the header fields and go to PREAMBLE. The first 0x55 appears on gmii_txd_o the next cycle.
- PREAMBLE: 7 cycles of 0x55, tx_en=1.
- SFD: 1 cycle of 0xD5, then HEADER.
- HEADER: 14 bytes in order dst, src, type, MSB byte first. CRC starts accumulating at the first header byte.
- PAYLOAD:
  - s_ready_o=1 combinationally.
  - An accepted byte appears on gmii_txd_o one cycle later.
  - A 16-bit payload counter increments per accepted byte.
  - Accepted with s_last_i: go to PAD if count<MIN_PAYLOAD, else go to FCS.
- PAD: emit 0x00 until the payload count reaches MIN_PAYLOAD. Pad bytes are included in the CRC.
- FCS:
  - 4 bytes of ~CRC, least-significant byte first, bit-reflected CRC-32 (poly 0xEDB88320).
  - frame_done_o pulses with the 4th byte.
  - Then IFG.
- IFG: tx_en=0, txd=0 for IFG_BYTES cycles, then IDLE. busy_o drops in the same cycle the state returns to IDLE.
- Underrun (s_valid_i=0 in PAYLOAD):
  - Emit one byte with tx_en=1, tx_er=1, txd=0; pulse underrun_o.
  - Go to DRAIN; no FCS is sent.
- Oversize (an accepted byte makes count>MAX_PAYLOAD without s_last_i): same abort as underrun.
- DRAIN: s_ready_o=1, tx_en=0. Discard input until a byte is accepted with s_last_i, then IFG.
- Simultaneous s_valid_i/s_last_i on the first payload byte: legal 1-byte payload, padded to MIN_PAYLOAD.
- Header inputs may change freely once latched.
- rst mid-frame: outputs go to 0 on the next edge and tx_en drops immediately. No IFG is enforced after reset.

Optional Feature:
- Macro TX_MAC_PAD_EN.
- Defined: PAD state present; minimum frame is 64 bytes including FCS.
- Undefined: PAD state is removed, and s_last_i always goes straight to FCS. Short payloads are sent unpadded (runt frames, for test use).

Decomposition:
- mac_if_pkg additions:
  - tx_state_t enum
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5
  - CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3
  - ETH_HDR_BYTES=14, FCS_BYTES=4
- One sub-module: crc32_byte, a combinational one-byte CRC-32 update (crc_in, data → crc_out), shared with the receive CRC checker.

Test Plan:
- 46-byte payload 0x00..0x2D, dst FF:FF:FF:FF:FF:FF, src 02:00:00:00:00:01, type 0x0800 → 7×0x55, 0xD5, header bytes in order, payload, 4 FCS bytes. tx_en high for exactly 72 cycles; CRC register over header+payload+FCS equals 0xDEBB20E3; frame_done_o pulses once.
- 1-byte payload 0xAB with s_last_i → 45 pad 0x00 bytes follow; 72 tx_en cycles; residue check passes. With TX_MAC_PAD_EN undefined: 27 tx_en cycles.
- Back-to-back frames with s_valid_i held high → exactly 12 cycles of tx_en=0 between frames; s_ready_o=0 throughout the IFG.
- s_valid_i dropped after payload byte 10 → one byte with tx_er=1, underrun_o pulse, no FCS. 5 further bytes ending in s_last_i are discarded, then IFG.
- 1501 bytes without s_last_i → tx_er and underrun_o at byte 1501; drain continues until s_last_i.
- rst asserted during HEADER → next cycle: tx_en=0, busy_o=0, s_ready_o=0. A new frame starting right after reset release is correct.

Source files
------------

// File: rtl/mac_if_pkg.sv
// Shared MAC definitions: transmit FSM states, framing byte values and CRC-32 constants.
// Used by the transmit framer and the receive-side CRC checker.
package mac_if_pkg;

    typedef enum logic [3:0] {
        TX_IDLE,
        TX_PREAMBLE,
        TX_SFD,
        TX_HEADER,
        TX_PAYLOAD,
        TX_PAD,
        TX_FCS,
        TX_DRAIN,
        TX_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int          PREAMBLE_LEN  = 7;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Register value after running the CRC over a frame including its own FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int          ETH_HDR_BYTES = 14;
    localparam int          FCS_BYTES     = 4;

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte update of the bit-reflected Ethernet CRC-32.
// Shared between the transmit framer and the receive CRC checker.
module crc32_byte
    import mac_if_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/tx_mac_framer.sv
// Transmit MAC framer: payload stream + header fields in, complete GMII frame out.
// Optional zero padding to minimum frame size is enabled by defining TX_MAC_PAD_EN.
module tx_mac_framer
    import mac_if_pkg::*;
#(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 46,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    input  logic [47:0] dst_mac_i,
    input  logic [47:0] src_mac_i,
    input  logic [15:0] ethertype_i,
    output logic [7:0]  gmii_txd_o,
    output logic        gmii_tx_en_o,
    output logic        gmii_tx_er_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underrun_o
);

    if (IFG_BYTES < 1 || MIN_PAYLOAD > MAX_PAYLOAD || MAX_PAYLOAD > 65534) begin : g_param_check
        $error("tx_mac_framer: invalid IFG_BYTES/MIN_PAYLOAD/MAX_PAYLOAD");
    end

    tx_state_t     state_reg, state_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [15:0]   pay_cnt_reg, pay_cnt_next;
    logic [111:0]  hdr_reg, hdr_next;
    logic [31:0]   crc_reg, crc_next;
    logic [7:0]    txd_reg, txd_next;
    logic          tx_en_reg, tx_en_next;
    logic          tx_er_reg, tx_er_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          underrun_reg, underrun_next;

    logic [7:0]    crc_data;
    logic [31:0]   crc_upd;
    logic          crc_en;
    logic [15:0]   pay_inc;
    logic [31:0]   fcs;

    // The byte entering the CRC depends only on registered state and the input
    // stream, so the update never loops back through the next-state logic.
    always_comb begin
        crc_data = 8'h00;
        if (state_reg == TX_HEADER) begin
            crc_data = hdr_reg[111:104];
        end else if (state_reg == TX_PAYLOAD) begin
            crc_data = s_data_i;
        end
    end

    crc32_byte u_crc (
        .crc_in  (crc_reg),
        .data    (crc_data),
        .crc_out (crc_upd)
    );

    assign fcs     = ~crc_reg;
    assign pay_inc = pay_cnt_reg + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= TX_IDLE;
            cnt_reg      <= 16'd0;
            pay_cnt_reg  <= 16'd0;
            hdr_reg      <= '0;
            crc_reg      <= CRC32_INIT;
            txd_reg      <= 8'h00;
            tx_en_reg    <= 1'b0;
            tx_er_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pay_cnt_reg  <= pay_cnt_next;
            hdr_reg      <= hdr_next;
            crc_reg      <= crc_next;
            txd_reg      <= txd_next;
            tx_en_reg    <= tx_en_next;
            tx_er_reg    <= tx_er_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            underrun_reg <= underrun_next;
        end
    end

    // Each state computes the byte that will be on the GMII pins after the
    // next edge, so every output is a flop with no combinational path.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pay_cnt_next  = pay_cnt_reg;
        hdr_next      = hdr_reg;
        crc_next      = crc_reg;
        txd_next      = 8'h00;
        tx_en_next    = 1'b0;
        tx_er_next    = 1'b0;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        underrun_next = 1'b0;
        crc_en        = 1'b0;
        s_ready_o     = 1'b0;

        case (state_reg)
            TX_IDLE: begin
                if (s_valid_i) begin
                    hdr_next     = {dst_mac_i, src_mac_i, ethertype_i};
                    crc_next     = CRC32_INIT;
                    txd_next     = PREAMBLE_BYTE;
                    tx_en_next   = 1'b1;
                    busy_next    = 1'b1;
                    cnt_next     = 16'd1;
                    pay_cnt_next = 16'd0;
                    state_next   = TX_PREAMBLE;
                end
            end

            TX_PREAMBLE: begin
                txd_next   = PREAMBLE_BYTE;
                tx_en_next = 1'b1;
                if (cnt_reg == 16'(PREAMBLE_LEN - 1)) begin
                    cnt_next   = 16'd0;
                    state_next = TX_SFD;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            TX_SFD: begin
                txd_next   = SFD_BYTE;
                tx_en_next = 1'b1;
                cnt_next   = 16'd0;
                state_next = TX_HEADER;
            end

            TX_HEADER: begin
                txd_next   = hdr_reg[111:104];
                tx_en_next = 1'b1;
                crc_en     = 1'b1;
                hdr_next   = {hdr_reg[103:0], 8'h00};
                if (cnt_reg == 16'(ETH_HDR_BYTES - 1)) begin
                    cnt_next   = 16'd0;
                    state_next = TX_PAYLOAD;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            TX_PAYLOAD: begin
                s_ready_o = 1'b1;
                if (s_valid_i && (s_last_i || pay_inc <= 16'(MAX_PAYLOAD))) begin
                    txd_next     = s_data_i;
                    tx_en_next   = 1'b1;
                    crc_en       = 1'b1;
                    pay_cnt_next = pay_inc;
                    if (s_last_i) begin
                        cnt_next = 16'd0;
`ifdef TX_MAC_PAD_EN
                        state_next = (pay_inc < 16'(MIN_PAYLOAD)) ? TX_PAD : TX_FCS;
`else
                        state_next = TX_FCS;
`endif
                    end
                end else begin
                    // Underrun or oversize: poison the frame and swallow the rest.
                    pay_cnt_next  = s_valid_i ? pay_inc : pay_cnt_reg;
                    tx_en_next    = 1'b1;
                    tx_er_next    = 1'b1;
                    underrun_next = 1'b1;
                    state_next    = (s_valid_i && s_last_i) ? TX_IFG : TX_DRAIN;
                    cnt_next      = 16'd0;
                end
            end

`ifdef TX_MAC_PAD_EN
            TX_PAD: begin
                tx_en_next   = 1'b1;
                crc_en       = 1'b1;
                pay_cnt_next = pay_inc;
                if (pay_inc >= 16'(MIN_PAYLOAD)) begin
                    cnt_next   = 16'd0;
                    state_next = TX_FCS;
                end
            end
`endif

            TX_FCS: begin
                tx_en_next = 1'b1;
                case (cnt_reg[1:0])
                    2'd0:    txd_next = fcs[7:0];
                    2'd1:    txd_next = fcs[15:8];
                    2'd2:    txd_next = fcs[23:16];
                    default: txd_next = fcs[31:24];
                endcase
                if (cnt_reg == 16'(FCS_BYTES - 1)) begin
                    done_next  = 1'b1;
                    cnt_next   = 16'd0;
                    state_next = TX_IFG;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            TX_DRAIN: begin
                s_ready_o = 1'b1;
                if (s_valid_i && s_last_i) begin
                    cnt_next   = 16'd0;
                    state_next = TX_IFG;
                end
            end

            TX_IFG: begin
                if (cnt_reg == 16'(IFG_BYTES - 1)) begin
                    cnt_next   = 16'd0;
                    busy_next  = 1'b0;
                    state_next = TX_IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            default: begin
                busy_next  = 1'b0;
                cnt_next   = 16'd0;
                state_next = TX_IDLE;
            end
        endcase

        if (crc_en) begin
            crc_next = crc_upd;
        end
    end

    assign gmii_txd_o   = txd_reg;
    assign gmii_tx_en_o = tx_en_reg;
    assign gmii_tx_er_o = tx_er_reg;
    assign busy_o       = busy_reg;
    assign frame_done_o = done_reg;
    assign underrun_o   = underrun_reg;

endmodule
